// File: rtl/timed_event_sequencer.sv
// Replays a programmed table of timed steps onto one registered output bit.
// Each step either samples din at the end of its delay or captures it at the start.
module timed_event_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_delay,
  input  logic          cfg_mode,
  input  logic [AW:0]   num_steps,
  input  logic          loop_en,
  input  logic          start,
  input  logic          abort,
  input  logic          din,
  output logic          dout,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] step_idx,
  output logic          upd
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t           state, state_nxt;
  logic [DW-1:0]    delay_tbl [DEPTH];
  logic [DEPTH-1:0] mode_tbl;
  logic [DW-1:0]    cnt;
  logic             cap;
  logic [AW:0]      steps_lat;
  logic             loop_lat;

  logic [AW:0]      eff_steps;
  logic             start_ok, upd_due, last;
  logic [AW-1:0]    next_idx;

  function automatic logic [DW-1:0] eff_delay(input logic [DW-1:0] d);
    return (d == '0) ? DW'(1) : d;
  endfunction

  assign eff_steps = (num_steps > DEPTH_L) ? DEPTH_L : num_steps;
  assign start_ok  = start && !abort && (eff_steps != '0);
  // The counter holds the cycles left in the current step; 1 means this edge updates.
  assign upd_due   = (state == RUN) && (cnt == DW'(1));
  assign last      = ({1'b0, step_idx} == (steps_lat - 1'b1));
  assign next_idx  = last ? '0 : step_idx + 1'b1;

  // Table has no reset and is frozen while a run is in progress.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE) begin
      delay_tbl[cfg_addr] <= cfg_delay;
      mode_tbl[cfg_addr]  <= cfg_mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = RUN;
      RUN: begin
        if (abort)                               state_nxt = IDLE;
        else if (upd_due && last && !loop_lat)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout      <= 1'b0;
      done      <= 1'b0;
      upd       <= 1'b0;
      step_idx  <= '0;
      cnt       <= '0;
      cap       <= 1'b0;
      steps_lat <= '0;
      loop_lat  <= 1'b0;
    end else begin
      done <= 1'b0;
      upd  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            steps_lat <= eff_steps;
            loop_lat  <= loop_en;
            step_idx  <= '0;
            cnt       <= eff_delay(delay_tbl[0]);
            cap       <= din;
          end else if (start && !abort) begin
            done <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            cnt <= cnt;
          end else if (upd_due) begin
            dout <= mode_tbl[step_idx] ? cap : din;
            upd  <= 1'b1;
            if (last && !loop_lat) begin
              done <= 1'b1;
            end else begin
              // Update edge doubles as the next step's start edge.
              step_idx <= next_idx;
              cnt      <= eff_delay(delay_tbl[next_idx]);
              cap      <= din;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_timed_event_sequencer.sv
// Randomized bench for timed_event_sequencer: a schedule model pushes expected
// updates/done pulses into queues, and a negedge monitor pops and compares them.
module tb_timed_event_sequencer;
  localparam int DEPTH = 8, AW = 3, DW = 8;

  logic          clk = 1'b0, rst;
  logic          cfg_we, cfg_mode, loop_en, start, abort, din;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_delay;
  logic [AW:0]   num_steps;
  logic          dout, busy, done, upd;
  logic [AW-1:0] step_idx;

  timed_event_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_delay(cfg_delay),
    .cfg_mode(cfg_mode), .num_steps(num_steps), .loop_en(loop_en), .start(start),
    .abort(abort), .din(din), .dout(dout), .busy(busy), .done(done),
    .step_idx(step_idx), .upd(upd)
  );

  always #5 clk = ~clk;

  int e = 0;
  always @(posedge clk) e <= e + 1;

  typedef struct {int cyc; logic val; logic [AW-1:0] idx;} upd_t;
  upd_t          upd_q[$];
  int            done_q[$];
  upd_t          u;
  int            dc;
  logic [DW-1:0] m_delay [DEPTH];
  logic          m_mode  [DEPTH];
  logic          din_arr [4096];
  logic          exp_dout = 1'b0;
  int            checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: pulse seen at edge %0d with nothing expected", name, e);
  endtask

  // Monitor: every output pulse must match the next scheduled expectation.
  always @(negedge clk) begin
    if (rst) exp_dout = 1'b0;
    else begin
      if (upd) begin
        if (upd_q.size() == 0) unexpected("upd_extra");
        else begin
          u = upd_q.pop_front();
          chk("upd_cycle", e, u.cyc);
          chk("upd_dout", dout, u.val);
          chk("upd_idx", step_idx, u.idx);
          exp_dout = u.val;
        end
      end else chk("dout_hold", dout, exp_dout);
      if (done) begin
        if (done_q.size() == 0) unexpected("done_extra");
        else begin
          dc = done_q.pop_front();
          chk("done_cycle", e, dc);
        end
      end
    end
  end

  task automatic wr(input int a, input int d, input bit m);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_delay = DW'(d); cfg_mode = m;
    m_delay[a] = DW'(d); m_mode[a] = m;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic din_fill(input int kind);
    for (int i = 0; i < 4096; i++)
      din_arr[i] = (kind == 2) ? 1'($urandom_range(0, 1)) : 1'(kind);
  endtask

  // Schedule model: update k lands at S0 + sum of effective delays 0..k.
  task automatic run(input int n, input bit lp, input int abort_at, input int wr_at);
    int s0, cnt, t_acc, prev, k, d, nidx, len, end_e;
    bit last;
    @(negedge clk);
    s0 = e + 1;
    cnt = (n > DEPTH) ? DEPTH : n;
    t_acc = 0; prev = 0; k = 0; len = 2; end_e = 0;
    if (cnt == 0) done_q.push_back(s0);
    else begin
      if (abort_at > 0) begin len = abort_at + 2; end_e = abort_at; end
      forever begin
        d = (m_delay[k] == 0) ? 1 : int'(m_delay[k]);
        t_acc += d;
        if (abort_at > 0 && t_acc >= abort_at) break;
        last = (k == cnt - 1);
        nidx = last ? (lp ? 0 : k) : k + 1;
        upd_q.push_back('{s0 + t_acc, m_mode[k] ? din_arr[prev] : din_arr[t_acc], AW'(nidx)});
        if (last && !lp) begin
          done_q.push_back(s0 + t_acc);
          len = t_acc + 3; end_e = t_acc;
          break;
        end
        prev = t_acc; k = nidx;
      end
    end
    start = 1'b1; num_steps = (AW+1)'(n); loop_en = lp; din = din_arr[0];
    for (int t = 1; t <= len; t++) begin
      @(negedge clk);
      chk("busy", busy, (cnt != 0) && (t - 1 < end_e));
      start = 1'b0;
      din   = din_arr[t];
      abort = (t == abort_at);
      cfg_we = (t == wr_at);
      cfg_addr = '0; cfg_delay = 8'd200; cfg_mode = ~m_mode[0];
    end
    @(negedge clk);
    abort = 1'b0; cfg_we = 1'b0;
    chk("upd_q_empty", upd_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
  endtask

  initial begin
    int s0;
    rst = 1'b1; cfg_we = 0; cfg_addr = '0; cfg_delay = '0; cfg_mode = 0;
    num_steps = '0; loop_en = 0; start = 0; abort = 0; din = 0;
    repeat (2) @(negedge clk);
    chk("rst_dout", dout, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_upd", upd, 0);   chk("rst_idx", step_idx, 0);
    #2 rst = 1'b0;

    // Directed waveform: din 1 at 25, 0 at 60, 1 at 100, 0 at 110.
    din_fill(0);
    for (int i = 25; i < 60; i++)   din_arr[i] = 1'b1;
    for (int i = 100; i < 110; i++) din_arr[i] = 1'b1;
    wr(0, 10, 0); wr(1, 45, 0); wr(2, 30, 0); wr(3, 20, 0);
    run(4, 0, 0, 0);
    wr(0, 10, 1); wr(1, 45, 1); wr(2, 30, 1); wr(3, 20, 1);
    run(4, 0, 0, 0);

    // Zero delay behaves as one cycle: back-to-back updates.
    din_fill(1);
    wr(0, 0, 0); wr(1, 1, 0);
    run(2, 0, 0, 0);

    // Looping run aborted mid-step; update at S0+9 must not happen.
    din_fill(2);
    wr(0, 3, 0); wr(1, 3, 1);
    run(2, 1, 8, 0);

    // Zero steps: single done pulse; oversized count clamps to DEPTH.
    run(0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) wr(i, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    din_fill(2);
    run(12, 0, 0, 0);

    // Write to entry 0 while busy is dropped; the next run uses the old entry.
    wr(0, 5, 0);
    din_fill(2);
    run(3, 0, 0, 2);
    din_fill(2);
    run(3, 0, 0, 0);

    // Random runs.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++)
        wr(i, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 25), 1'($urandom_range(0, 1)));
      din_fill(2);
      if (r % 3 == 2) run($urandom_range(1, 10), 1, $urandom_range(5, 120), 0);
      else            run($urandom_range(0, 15), 0, 0, 0);
    end

    // Async reset mid-delay clears outputs before the next clock edge.
    for (int i = 0; i < 4; i++) wr(i, 20, 0);
    din_fill(1);
    @(negedge clk);
    s0 = e + 1;
    upd_q.push_back('{s0 + 20, 1'b1, AW'(1)});
    start = 1'b1; num_steps = 4'd4; loop_en = 0; din = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dout", dout, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_idx", step_idx, 0);
    chk("rst_upd_q_empty", upd_q.size(), 0);
    upd_q.delete(); done_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
